// File: rtl/counter_mod_n.sv
// Modulo-(MAX+1) up/down digit counter with clear, clamped parallel load and
// same-cycle carry/borrow outputs for building cascaded digit chains.
module counter_mod_n #(
  parameter int WIDTH = 4,
  parameter int MAX   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             carry_in,
  input  logic             down,
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             load_err
);

  if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("counter_mod_n: MAX=%0d outside 1..2**WIDTH-1 for WIDTH=%0d", MAX, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] value_q, value_d;
  logic             load_err_q, load_err_d;

  always_comb begin
    value_d    = value_q;
    load_err_d = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      if (load_value > MAX_V) begin
        value_d    = MAX_V;
        load_err_d = 1'b1;
      end else begin
        value_d = load_value;
      end
    end else if (carry_in) begin
      if (down) begin
        value_d = (value_q == '0) ? MAX_V : value_q - ONE_V;
      end else begin
        value_d = (value_q == MAX_V) ? '0 : value_q + ONE_V;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      load_err_q <= load_err_d;
    end
  end

  // Wrap flags are combinational so the next digit steps on the same edge.
  assign carry_out  = carry_in & ~down & ~clear & ~load & (value_q == MAX_V);
  assign borrow_out = carry_in &  down & ~clear & ~load & (value_q == '0);
  assign value      = value_q;
  assign load_err   = load_err_q;

endmodule
